gray_decoder: RTL and testbench
===============================

# gray_decoder

Receive-side companion to the `gray` counter. It samples a Gray-coded count bus and converts it to binary. It checks that every new value is a legal single forward step, reports wrap-around as `Overflow`, and tracks lock and error status. It sits at the consuming end of any Gray-coded count (counter outputs, clock-domain-crossed pointers) and gives downstream logic a trusted binary value.

## Interface
- `WIDTH`, 3: width of the Gray input and the binary output.
- `RELOCK_N`, 4: consecutive legal forward steps needed to regain lock after an error (range 1..15).
- `Clk` input 1: rising-edge clock; the only clock.
- `Reset` input 1: synchronous, active-high reset.
- `En` input 1: sample strobe; `Gray` is sampled only on edges where `En`=1.
- `Gray` input WIDTH: Gray-coded count from the producer.
- `Output` output WIDTH: registered binary decode of the last accepted sample.
- `Overflow` output 1: one-cycle pulse when a locked forward step wraps from 2^WIDTH-1 to 0.
- `Error` output 1: one-cycle pulse on an illegal transition.
- `Locked` output 1: level; 1 while the stream is tracked as legal.
- `ErrCount` output 8: saturating count of illegal transitions.

## Operation
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
- The reference value is the last accepted Gray sample. d = popcount(Gray ^ ref).
- Legal forward step: d==1 and decode(Gray) == (decode(ref)+1) mod 2^WIDTH.
- Hold: d==0. Legal, no status change, relock counter unchanged.
- Anything else is illegal. This covers backward single-bit steps and d>=2.
- FSM states:
  - `SYNC` (reset state): the first `En` sample captures the reference, updates `Output`, goes to `LOCKED`. No `Error` or `Overflow` on this sample.
  - `LOCKED`: a forward step updates `Output`; `Overflow`=1 if the old binary was all-ones. An illegal sample pulses `Error`, increments `ErrCount`, captures the sample as the new reference, updates `Output`, clears the relock counter, goes to `RELOCK`.
  - `RELOCK`: a forward step updates `Output` and increments the relock counter (4 bits). When the counter reaches `RELOCK_N`, go to `LOCKED`. An illegal sample pulses `Error`, increments `ErrCount`, captures the reference, clears the counter. `Overflow` is never asserted in this state.
- `ErrCount` saturates at 255. Further errors still pulse `Error`.
- `Locked`=1 exactly when the state is `LOCKED`.
- `En`=0: state, reference, `Output`, counters hold; pulses deassert.

## Timing
- All outputs are registered. An `En` sample at edge N is reflected on `Output`, `Overflow`, `Error`, `Locked` and `ErrCount` after edge N. Latency is 1 cycle.
- `Overflow` and `Error` are high for exactly one cycle per triggering sample. They are never both high in the same cycle.
- Back-to-back `En` every cycle is supported at full rate with no bubbles.
- Reset values: `Output`=0, `Overflow`=0, `Error`=0, `Locked`=0, `ErrCount`=0, state `SYNC`, reference 0, relock counter 0.
- `Reset` wins over `En` on the same edge. Reset mid-stream discards lock and counts; the next `En` sample resynchronises silently.
- `Locked` rises after the edge that accepts the `RELOCK_N`-th forward step.

## Structure
- Shared package `gray_pkg`:
  - state enum (`SYNC`, `LOCKED`, `RELOCK`)
  - `ERRCNT_W`=8
  - a `gray2bin` function, reused by other Gray consumers
- One combinational sub-module, `gray_step_check`. It takes the current and reference Gray values and outputs decoded binary, `is_hold`, `is_fwd` and `is_wrap`.
- The FSM, counters and output registers live in `gray_decoder`.

## Test plan
- Reset, then `En`=1 feeding 000,001,011,010,110,111,101,100,000 on consecutive cycles. Expected `Output` 0,1,2,3,4,5,6,7,0, with `Locked`=1 from the first sample. `Overflow` pulses once, after the final 000, and `Error` never asserts.
- While locked at 011, feed 110 (d=2). Expected: `Error` pulse, `ErrCount`=1, `Locked`=0, `Output`=4. Then 111,101,100,000 re-lock: `Locked`=1 after the fourth step. No `Overflow` on that 100→000 wrap.
- While locked at 010, feed 011 (backward single-bit step). Expected: `Error` pulse, `Output`=2, state `RELOCK`.
- Hold at 001 for 5 cycles, with `En` toggling 0/1 and `Gray` wiggling while `En`=0. Expected: no output change, no pulses.
- Alternate 000/011 for 300 samples. Expected: `ErrCount` saturates at 255, and `Error` still pulses every sample.
- Assert `Reset` mid-stream with `Gray`=101 and `En`=1 on the same edge. Expected: all outputs return to reset values. The next sample of 101 gives `Output`=6, `Locked`=1 and no `Error`.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for Gray-code consumers: FSM state encoding, counter width
// and a generic Gray-to-binary conversion.
package gray_pkg;

    localparam int unsigned ERRCNT_W   = 8;
    localparam int unsigned RELOCK_W   = 4;
    localparam int unsigned GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        RELOCK = 2'd2
    } gray_state_e;

    // Prefix XOR from the MSB down; zero-extended inputs decode unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// Classifies a new Gray sample against the reference: hold, forward step, wrap.
module gray_step_check
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] ref_i,
    output logic [WIDTH-1:0] bin_o,
    output logic             is_hold_o,
    output logic             is_fwd_o,
    output logic             is_wrap_o
);

    logic [WIDTH-1:0] bin_ref;

    always_comb begin
        bin_o     = WIDTH'(gray2bin(GRAY_MAX_W'(cur_i)));
        bin_ref   = WIDTH'(gray2bin(GRAY_MAX_W'(ref_i)));
        is_hold_o = (cur_i == ref_i);
        is_fwd_o  = ($countones(cur_i ^ ref_i) == 1) && (bin_o == WIDTH'(bin_ref + 1'b1));
        is_wrap_o = (bin_ref == '1);
    end

endmodule

// File: rtl/gray_decoder.sv
// Gray-coded count receiver: decodes to binary, validates single forward steps,
// and tracks lock, wrap and error status with registered outputs.
module gray_decoder
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned RELOCK_N = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                En,
    input  logic [WIDTH-1:0]    Gray,
    output logic [WIDTH-1:0]    Output,
    output logic                Overflow,
    output logic                Error,
    output logic                Locked,
    output logic [ERRCNT_W-1:0] ErrCount
);

    gray_state_e          state_q, state_d;
    logic [WIDTH-1:0]     ref_q, ref_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;
    logic [ERRCNT_W-1:0]  errcnt_q, errcnt_d;
    logic [RELOCK_W-1:0]  relock_q, relock_d;

    logic [WIDTH-1:0]     bin;
    logic                 is_hold, is_fwd, is_wrap;

    gray_step_check #(.WIDTH(WIDTH)) u_step (
        .cur_i     (Gray),
        .ref_i     (ref_q),
        .bin_o     (bin),
        .is_hold_o (is_hold),
        .is_fwd_o  (is_fwd),
        .is_wrap_o (is_wrap)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= SYNC;
            ref_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            errcnt_q <= '0;
            relock_q <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            errcnt_q <= errcnt_d;
            relock_q <= relock_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        out_d    = out_q;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;
        relock_d = relock_q;

        if (En) begin
            unique case (state_q)
                SYNC: begin
                    ref_d   = Gray;
                    out_d   = bin;
                    state_d = LOCKED;
                end
                LOCKED, RELOCK: begin
                    if (is_hold) begin
                        // legal hold: nothing changes
                    end else if (is_fwd) begin
                        ref_d = Gray;
                        out_d = bin;
                        if (state_q == LOCKED) begin
                            ovf_d = is_wrap;
                        end else begin
                            relock_d = relock_q + RELOCK_W'(1);
                            if (relock_d == RELOCK_W'(RELOCK_N)) begin
                                state_d = LOCKED;
                            end
                        end
                    end else begin
                        // illegal step: resynchronise on this sample
                        err_d    = 1'b1;
                        ref_d    = Gray;
                        out_d    = bin;
                        relock_d = '0;
                        state_d  = RELOCK;
                        if (errcnt_q != '1) begin
                            errcnt_d = errcnt_q + ERRCNT_W'(1);
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    assign Output   = out_q;
    assign Overflow = ovf_q;
    assign Error    = err_q;
    assign Locked   = locked_q;
    assign ErrCount = errcnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Directed self-checking bench for gray_decoder (WIDTH=3, RELOCK_N=4).
module tb_gray_decoder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       En;
    logic [2:0] Gray;
    logic [2:0] Output;
    logic       Overflow;
    logic       Error;
    logic       Locked;
    logic [7:0] ErrCount;

    int errors = 0;
    int checks = 0;

    logic [2:0] cnt_seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                3'b111, 3'b101, 3'b100, 3'b000};

    gray_decoder #(.WIDTH(3), .RELOCK_N(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Gray     (Gray),
        .Output   (Output),
        .Overflow (Overflow),
        .Error    (Error),
        .Locked   (Locked),
        .ErrCount (ErrCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic [2:0] g);
        En   = en;
        Gray = g;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] o, input logic ov,
                           input logic er, input logic lk, input logic [7:0] ec);
        chk({tag, ".out"}, 32'(Output), 32'(o));
        chk({tag, ".ovf"}, 32'(Overflow), 32'(ov));
        chk({tag, ".err"}, 32'(Error), 32'(er));
        chk({tag, ".lock"}, 32'(Locked), 32'(lk));
        chk({tag, ".ecnt"}, 32'(ErrCount), 32'(ec));
    endtask

    initial begin
        Reset = 1'b1;
        En    = 1'b0;
        Gray  = 3'b000;
        repeat (2) @(posedge Clk);
        #1;
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        Reset = 1'b0;

        // full count including wrap
        for (int i = 0; i < 9; i++) begin
            step(1'b1, cnt_seq[i]);
            chk_all($sformatf("count%0d", i), 3'(i % 8), (i == 8), 1'b0, 1'b1, 8'd0);
        end

        // d=2 jump from 011, then relock through a wrap
        step(1'b1, 3'b001);
        step(1'b1, 3'b011);
        chk_all("at011", 3'd2, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b1, 3'b110);
        chk_all("jump", 3'd4, 1'b0, 1'b1, 1'b0, 8'd1);
        step(1'b1, 3'b111);
        chk_all("relock1", 3'd5, 1'b0, 1'b0, 1'b0, 8'd1);
        step(1'b1, 3'b101);
        chk_all("relock2", 3'd6, 1'b0, 1'b0, 1'b0, 8'd1);
        step(1'b1, 3'b100);
        chk_all("relock3", 3'd7, 1'b0, 1'b0, 1'b0, 8'd1);
        step(1'b1, 3'b000);
        chk_all("relock4", 3'd0, 1'b0, 1'b0, 1'b1, 8'd1);

        // backward single-bit step 010 -> 011
        step(1'b1, 3'b001);
        step(1'b1, 3'b011);
        step(1'b1, 3'b010);
        chk_all("at010", 3'd3, 1'b0, 1'b0, 1'b1, 8'd1);
        step(1'b1, 3'b011);
        chk_all("backward", 3'd2, 1'b0, 1'b1, 1'b0, 8'd2);
        step(1'b1, 3'b010);
        step(1'b1, 3'b110);
        step(1'b1, 3'b111);
        chk_all("bk_relock3", 3'd5, 1'b0, 1'b0, 1'b0, 8'd2);
        step(1'b1, 3'b101);
        chk_all("bk_relock4", 3'd6, 1'b0, 1'b0, 1'b1, 8'd2);

        // hold at 001 with En toggling and Gray wiggling while disabled
        step(1'b1, 3'b100);
        step(1'b1, 3'b000);
        step(1'b1, 3'b001);
        chk_all("at001", 3'd1, 1'b0, 1'b0, 1'b1, 8'd2);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'(i * 3 + 2));
            chk_all($sformatf("hold_off%0d", i), 3'd1, 1'b0, 1'b0, 1'b1, 8'd2);
            step(1'b1, 3'b001);
            chk_all($sformatf("hold_on%0d", i), 3'd1, 1'b0, 1'b0, 1'b1, 8'd2);
        end

        // alternate 000/011: every sample illegal, counter saturates
        for (int i = 0; i < 300; i++) begin
            step(1'b1, (i % 2 == 0) ? 3'b000 : 3'b011);
            chk($sformatf("sat_err%0d", i), 32'(Error), 32'd1);
            chk($sformatf("sat_ovf%0d", i), 32'(Overflow), 32'd0);
            if (i == 251) chk("sat_ecnt254", 32'(ErrCount), 32'd254);
            if (i == 252) chk("sat_ecnt255", 32'(ErrCount), 32'd255);
        end
        chk_all("sat_end", 3'd2, 1'b0, 1'b1, 1'b0, 8'd255);

        // reset wins over En on the same edge, then silent resync
        Reset = 1'b1;
        step(1'b1, 3'b101);
        chk_all("midreset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        Reset = 1'b0;
        step(1'b1, 3'b101);
        chk_all("resync", 3'd6, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 3'b000);
        chk_all("resync_idle", 3'd6, 1'b0, 1'b0, 1'b1, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
